keypad_scanner: RTL and testbench
=================================

Name: keypad_scanner

Overview:
- Parametrised matrix-keypad scanner: drives one-hot column strobes, samples the row lines, debounces over whole scan frames and reports key events as an index code with a one-cycle strobe.
- Adds reset, configurable matrix size and scan rate, press/release debounce, multi-key rejection and optional auto-repeat.
- Sits between the board keypad pins and the command decoder; the decoder maps raw key indices to functions.

Parameters:
- NUM_ROWS, 4, row input count (>=1).
- NUM_COLS, 4, column output count (>=2).
- CLK_DIV, 100000, clk cycles per column dwell (>=4).
- DEBOUNCE_SCANS, 3, consecutive identical frames required to accept a press or a release (>=1).
- REPEAT_SCANS, 0, frames between auto-repeat strobes while held; 0 disables repeat.
- CODE_W, 4, key_code width; must satisfy 2^CODE_W >= NUM_ROWS*NUM_COLS.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- row  in  NUM_ROWS  row sense lines, active high, asynchronous to clk.
- col  out  NUM_COLS  one-hot column drive, active high.
- key_code  out  CODE_W  index of the accepted key = row_idx*NUM_COLS + col_idx; holds its value between events.
- key_valid  out  1  one-clk strobe: key accepted, or auto-repeat.
- key_held  out  1  level: an accepted key is currently held.
- key_release  out  1  one-clk strobe: held key released after debounce.
- multi_key  out  1  level: the last completed frame saw more than one closed key.

Behaviour:
- Interface: single clock clk; reset rst_n is asynchronous, active-low. All state is cleared immediately on assertion; release is synchronous to clk.
- Reset values:
  - col = 1 (column 0 driven).
  - key_code = 0; key_valid, key_held, key_release and multi_key = 0.
  - FSM = IDLE; all counters = 0.
- row passes through a 2-flop synchronizer before use.
- Divider: counts 0..CLK_DIV-1. At terminal count (the "tick"):
  - The synchronized row for the current column is captured.
  - col rotates left; col[NUM_COLS-1] wraps to col[0].
  - The divider returns to 0.
- Frame: NUM_COLS ticks, columns 0..NUM_COLS-1. At the tick of the last column, the frame is classified:
  - NONE: no row bit set in any column.
  - SINGLE(c): exactly one bit set; c is its index.
  - MULTI: two or more bits set.
- multi_key updates at every frame end.
- All FSM transitions and counters advance only at frame end.
- IDLE:
  - SINGLE(c): cand = c, cnt = 1, go to PRESS_DB.
  - Otherwise: stay in IDLE.
- PRESS_DB:
  - SINGLE(cand): cnt+1.
  - SINGLE(other): cand = other, cnt = 1.
  - NONE or MULTI: go to IDLE.
- Acceptance:
  - Occurs on the frame where cnt reaches DEBOUNCE_SCANS. With DEBOUNCE_SCANS=1 this is the first SINGLE frame, taken directly from IDLE.
  - On acceptance: key_code = cand, key_valid pulses for 1 clk, key_held = 1, rpt = 0, go to HELD.
- HELD:
  - SINGLE(cand): rpt+1. If REPEAT_SCANS != 0 and rpt reaches REPEAT_SCANS: pulse key_valid (key_code unchanged), rpt = 0.
  - Any other classification: cnt = 1, go to REL_DB.
- REL_DB:
  - NONE: cnt+1.
  - SINGLE(cand): go back to HELD with no new key_valid; rpt is not reset.
  - SINGLE(other) or MULTI: cnt = 0, stay in REL_DB.
- Release:
  - Occurs when cnt reaches DEBOUNCE_SCANS in REL_DB.
  - On release: key_held = 0, key_release pulses for 1 clk, go to IDLE.
  - A new key is accepted only after a full release followed by a fresh press debounce.
- Strobe timing:
  - key_valid and key_release assert on the clk after the frame-end tick and are high for exactly 1 clk.
  - They never assert together.
  - Press-to-valid latency is at most (DEBOUNCE_SCANS+1)*NUM_COLS*CLK_DIV + 3 clk.
- Reset mid-operation: when rst_n asserts during HELD, all outputs return to reset values immediately, with no key_release strobe.

Test Plan:
- Reset: rst_n=0 mid-frame -> col=0001, key_valid=0, key_held=0, key_code=0 immediately. After release, col rotates 0001->0010->0100->1000->0001 every 4 clk. Bench config: CLK_DIV=4, DEBOUNCE_SCANS=3, 4x4.
- Clean press: row[1] high whenever col[2] is driven, held 5 frames -> one key_valid with key_code=6 at the end of frame 3; key_held=1. Release for 3 frames -> key_release at the end of the 3rd empty frame; key_held=0.
- Bounce: key 6 present in frames 1-2, absent in frame 3, present in frames 4-6 -> no strobe through frame 5; key_valid with key_code=6 at the end of frame 6.
- Multi-key: keys 0 and 15 closed together for 5 frames -> multi_key=1 from the end of frame 1, no key_valid, FSM stays IDLE. Drop key 15 -> key_valid with key_code=0 three frames later; multi_key=0.
- Auto-repeat: REPEAT_SCANS=5, key 9 held 20 frames -> key_valid at frames 3, 8, 13 and 18; no key_release until after the release debounce.
- Glitch during hold: key 3 held, one empty frame, then present again -> no key_release, no extra key_valid, key_held stays 1.

Source files
------------

// File: rtl/keypad_scanner.sv
// keypad_scanner: strobes matrix columns one-hot, samples rows, debounces whole frames, reports key events.
// Latency: strobes rise 1 clk after the frame-end tick; press-to-valid <= (DEBOUNCE_SCANS+1)*NUM_COLS*CLK_DIV+3 clk.
// Backpressure: none; key_valid/key_release are single-cycle strobes and must be consumed when seen.
//
// Ports:
//   clk, rst_n   system clock, asynchronous active-low reset
//   row          row sense lines (active high, asynchronous, synchronised internally)
//   col          one-hot column drive (active high)
//   key_code     index of the accepted key (row_idx*NUM_COLS + col_idx), held between events
//   key_valid    one-clk strobe on acceptance or auto-repeat
//   key_held     level, an accepted key is held
//   key_release  one-clk strobe when the held key has been released after debounce
//   multi_key    level, the last completed frame had more than one closed key
module keypad_scanner #(
  parameter int NUM_ROWS       = 4,
  parameter int NUM_COLS       = 4,
  parameter int CLK_DIV        = 100000,
  parameter int DEBOUNCE_SCANS = 3,
  parameter int REPEAT_SCANS   = 0,
  parameter int CODE_W         = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_ROWS-1:0] row,
  output logic [NUM_COLS-1:0] col,
  output logic [CODE_W-1:0]   key_code,
  output logic                key_valid,
  output logic                key_held,
  output logic                key_release,
  output logic                multi_key
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int COL_W = $clog2(NUM_COLS);
  localparam int ROW_W = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
  localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);
  localparam int RPT_W = $clog2(REPEAT_SCANS + 2);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PRESS_DB,
    ST_HELD,
    ST_REL_DB
  } state_t;

  // Synchroniser, divider and column strobe
  logic [NUM_ROWS-1:0] row_s1_q, row_s2_q;
  logic [DIV_W-1:0]    div_q;
  logic [NUM_COLS-1:0] col_q;
  logic [COL_W-1:0]    col_idx_q;
  logic                tick, last_col, frame_end;

  assign tick      = (div_q == DIV_W'(CLK_DIV - 1));
  assign last_col  = (col_idx_q == COL_W'(NUM_COLS - 1));
  assign frame_end = tick && last_col;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_s1_q  <= '0;
      row_s2_q  <= '0;
      div_q     <= '0;
      col_q     <= NUM_COLS'(1);
      col_idx_q <= '0;
    end else begin
      row_s1_q <= row;
      row_s2_q <= row_s1_q;
      if (tick) begin
        div_q     <= '0;
        col_q     <= {col_q[NUM_COLS-2:0], col_q[NUM_COLS-1]};
        col_idx_q <= last_col ? '0 : col_idx_q + 1'b1;
      end else begin
        div_q <= div_q + 1'b1;
      end
    end
  end

  // Frame accumulator: only the number of closed keys (saturating at 2)
  // and the index of the first one are needed to classify a frame.
  logic [1:0]        acc_cnt_q, acc_cnt_d;
  logic [CODE_W-1:0] acc_code_q, acc_code_d;
  logic [1:0]        hits;
  logic [ROW_W-1:0]  hit_row;
  logic [CODE_W-1:0] hit_code;
  logic [2:0]        hit_sum;
  logic [1:0]        frame_cnt;
  logic [CODE_W-1:0] frame_code;

  always_comb begin
    hits    = 2'd0;
    hit_row = '0;
    for (int r = 0; r < NUM_ROWS; r++) begin
      if (row_s2_q[r]) begin
        if (hits != 2'd2) hits = hits + 2'd1;
        hit_row = ROW_W'(r);
      end
    end
    hit_code   = CODE_W'(hit_row) * CODE_W'(NUM_COLS) + CODE_W'(col_idx_q);
    hit_sum    = {1'b0, acc_cnt_q} + {1'b0, hits};
    frame_cnt  = (hit_sum > 3'd2) ? 2'd2 : hit_sum[1:0];
    frame_code = (acc_cnt_q == 2'd0 && hits == 2'd1) ? hit_code : acc_code_q;

    acc_cnt_d  = acc_cnt_q;
    acc_code_d = acc_code_q;
    if (tick) begin
      if (last_col) begin
        acc_cnt_d  = 2'd0;
        acc_code_d = '0;
      end else begin
        acc_cnt_d  = frame_cnt;
        acc_code_d = frame_code;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_cnt_q  <= 2'd0;
      acc_code_q <= '0;
    end else begin
      acc_cnt_q  <= acc_cnt_d;
      acc_code_q <= acc_code_d;
    end
  end

  logic is_none, is_single, is_multi, same_key;
  assign is_none   = (frame_cnt == 2'd0);
  assign is_single = (frame_cnt == 2'd1);
  assign is_multi  = (frame_cnt == 2'd2);

  // Debounce / hold FSM, advances only at frame end
  state_t            state_q, state_d;
  logic [CODE_W-1:0] cand_q, cand_d;
  logic [CODE_W-1:0] code_q, code_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
  logic [RPT_W-1:0]  rpt_q, rpt_d, rpt_inc;
  logic              valid_q, valid_d;
  logic              held_q, held_d;
  logic              rel_q, rel_d;
  logic              multi_q, multi_d;

  assign same_key = (frame_code == cand_q);
  assign cnt_inc  = cnt_q + 1'b1;
  assign rpt_inc  = rpt_q + 1'b1;

  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    code_d  = code_q;
    cnt_d   = cnt_q;
    rpt_d   = rpt_q;
    held_d  = held_q;
    multi_d = multi_q;
    valid_d = 1'b0;
    rel_d   = 1'b0;

    if (frame_end) begin
      multi_d = is_multi;
      case (state_q)
        ST_IDLE: begin
          if (is_single) begin
            cand_d  = frame_code;
            cnt_d   = CNT_W'(1);
            state_d = ST_PRESS_DB;
          end
        end
        ST_PRESS_DB: begin
          if (is_single && same_key) begin
            cnt_d = cnt_inc;
          end else if (is_single) begin
            cand_d = frame_code;
            cnt_d  = CNT_W'(1);
          end else begin
            cnt_d   = '0;
            state_d = ST_IDLE;
          end
        end
        ST_HELD: begin
          if (is_single && same_key) begin
            if (REPEAT_SCANS != 0 && rpt_inc == RPT_W'(REPEAT_SCANS)) begin
              valid_d = 1'b1;
              rpt_d   = '0;
            end else begin
              rpt_d = rpt_inc;
            end
          end else begin
            // The first non-matching frame already counts toward release.
            cnt_d   = CNT_W'(1);
            state_d = ST_REL_DB;
          end
        end
        ST_REL_DB: begin
          if (is_none) begin
            cnt_d = cnt_inc;
          end else if (is_single && same_key) begin
            // Bounce back to the held key: no new strobe, repeat phase kept.
            cnt_d   = '0;
            state_d = ST_HELD;
          end else begin
            cnt_d = '0;
          end
        end
        default: state_d = ST_IDLE;
      endcase

      // Acceptance also covers DEBOUNCE_SCANS=1 straight from IDLE.
      if (state_d == ST_PRESS_DB && cnt_d == CNT_W'(DEBOUNCE_SCANS)) begin
        state_d = ST_HELD;
        code_d  = cand_d;
        valid_d = 1'b1;
        held_d  = 1'b1;
        rpt_d   = '0;
        cnt_d   = '0;
      end

      if (state_d == ST_REL_DB && is_none && cnt_d == CNT_W'(DEBOUNCE_SCANS)) begin
        state_d = ST_IDLE;
        held_d  = 1'b0;
        rel_d   = 1'b1;
        cnt_d   = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cand_q  <= '0;
      code_q  <= '0;
      cnt_q   <= '0;
      rpt_q   <= '0;
      valid_q <= 1'b0;
      held_q  <= 1'b0;
      rel_q   <= 1'b0;
      multi_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cand_q  <= cand_d;
      code_q  <= code_d;
      cnt_q   <= cnt_d;
      rpt_q   <= rpt_d;
      valid_q <= valid_d;
      held_q  <= held_d;
      rel_q   <= rel_d;
      multi_q <= multi_d;
    end
  end

  assign col         = col_q;
  assign key_code    = code_q;
  assign key_valid   = valid_q;
  assign key_held    = held_q;
  assign key_release = rel_q;
  assign multi_key   = multi_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: drives a 4x4 keypad model frame by frame and compares against a frame-level reference.
// Latency: outputs compared 1 ns after each frame-end edge; column strobe checked at every tick.
// Backpressure: not applicable.
module tb_keypad_scanner;

  localparam int NR   = 4;
  localparam int NC   = 4;
  localparam int CD   = 4;
  localparam int DEB  = 3;
  localparam int RPT  = 5;
  localparam int CW   = 4;
  localparam int FRAME_CLKS = NC * CD;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [NR-1:0] row;
  logic [NC-1:0] col;
  logic [CW-1:0] key_code;
  logic          key_valid, key_held, key_release, multi_key;
  logic [15:0]   keys = '0;

  keypad_scanner #(
    .NUM_ROWS(NR), .NUM_COLS(NC), .CLK_DIV(CD),
    .DEBOUNCE_SCANS(DEB), .REPEAT_SCANS(RPT), .CODE_W(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .row(row), .col(col),
    .key_code(key_code), .key_valid(key_valid), .key_held(key_held),
    .key_release(key_release), .multi_key(multi_key)
  );

  always #5 clk = ~clk;

  // Physical keypad: a closed key connects its column drive to its row line.
  always_comb begin
    row = '0;
    for (int r = 0; r < NR; r++)
      for (int c = 0; c < NC; c++)
        if (col[c] && keys[r*NC+c]) row[r] = 1'b1;
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  // Strobe activity seen on every cycle, compared with model totals at the end.
  int seen_valid = 0, seen_rel = 0, seen_both = 0;
  always @(negedge clk) begin
    if (key_valid) seen_valid++;
    if (key_release) seen_rel++;
    if (key_valid && key_release) seen_both++;
  end

  // Reference model, frame granularity
  int hist[$];
  bit m_held, m_in_rel;
  int m_rpt, m_rel_cnt, e_code;
  bit e_valid, e_rel, e_multi;
  int tot_valid = 0, tot_rel = 0;

  task automatic model_reset();
    hist.delete();
    m_held = 0; m_in_rel = 0; m_rpt = 0; m_rel_cnt = 0;
    e_code = 0; e_valid = 0; e_rel = 0; e_multi = 0;
  endtask

  task automatic model_step(input logic [15:0] k);
    int n, idx;
    bit run_ok;
    n = $countones(k);
    idx = -1;
    if (n == 1) for (int i = 0; i < 16; i++) if (k[i]) idx = i;
    e_multi = (n >= 2);
    e_valid = 0;
    e_rel   = 0;
    hist.push_back(idx);
    if (hist.size() > DEB) void'(hist.pop_front());
    if (!m_held) begin
      // Accept when the last DEB frames all showed the same single key.
      if (hist.size() == DEB) begin
        run_ok = 1;
        foreach (hist[i]) if (hist[i] < 0 || hist[i] != hist[0]) run_ok = 0;
        if (run_ok) begin
          m_held = 1; m_in_rel = 0; m_rpt = 0;
          e_code = hist[0]; e_valid = 1;
        end
      end
    end else if (idx == e_code) begin
      if (m_in_rel) m_in_rel = 0;
      else begin
        m_rpt++;
        if (RPT != 0 && m_rpt == RPT) begin e_valid = 1; m_rpt = 0; end
      end
    end else begin
      if (!m_in_rel) begin m_in_rel = 1; m_rel_cnt = 1; end
      else if (n == 0) m_rel_cnt++;
      else m_rel_cnt = 0;
      if (n == 0 && m_rel_cnt >= DEB) begin
        m_held = 0; m_in_rel = 0; e_rel = 1;
      end
    end
    tot_valid += int'(e_valid);
    tot_rel   += int'(e_rel);
  endtask

  // One frame with a fixed key pattern; call starts right after a frame-end edge
  // (or right after reset release).
  task automatic run_frame(input logic [15:0] k);
    logic [NC-1:0] exp_col;
    keys = k;
    for (int t = 1; t <= FRAME_CLKS; t++) begin
      @(posedge clk); #1;
      if (t % CD == 0) begin
        exp_col = NC'(1 << ((t / CD) % NC));
        check("col", 32'(col), 32'(exp_col));
      end
    end
    model_step(k);
    check("key_valid",   32'(key_valid),   32'(e_valid));
    check("key_release", 32'(key_release), 32'(e_rel));
    check("key_held",    32'(key_held),    32'(m_held));
    check("key_code",    32'(key_code),    32'(e_code));
    check("multi_key",   32'(multi_key),   32'(e_multi));
  endtask

  task automatic run_n(input logic [15:0] k, input int n);
    for (int i = 0; i < n; i++) run_frame(k);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_col"},     32'(col),         32'd1);
    check({tag, "_valid"},   32'(key_valid),   32'd0);
    check({tag, "_held"},    32'(key_held),    32'd0);
    check({tag, "_code"},    32'(key_code),    32'd0);
    check({tag, "_release"}, 32'(key_release), 32'd0);
    check({tag, "_multi"},   32'(multi_key),   32'd0);
  endtask

  function automatic logic [15:0] kbit(input int i);
    logic [15:0] one;
    one = 16'd1;
    return one << i;
  endfunction

  initial begin
    logic [15:0] prev, k;
    model_reset();
    #12;
    check_reset_vals("rst_init");
    @(negedge clk);
    rst_n = 1'b1;

    // Clean press of key 6 (row 1, col 2), then release
    run_n(kbit(6), 5);
    run_n('0, 3);

    // Bouncing press of key 6
    run_n(kbit(6), 2);
    run_frame('0);
    run_n(kbit(6), 3);
    run_n('0, 3);

    // Keys 0 and 15 together, then 15 dropped
    run_n(kbit(0) | kbit(15), 5);
    run_n(kbit(0), 4);
    run_n('0, 3);

    // Auto-repeat on key 9
    run_n(kbit(9), 20);
    run_n('0, 3);

    // One empty frame glitch while key 3 is held
    run_n(kbit(3), 4);
    run_frame('0);
    run_n(kbit(3), 3);
    run_n('0, 3);

    // Randomised frames
    prev = '0;
    for (int f = 0; f < 40; f++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3: k = prev;
        4, 5:       k = '0;
        6, 7, 8:    k = kbit($urandom_range(0, 15));
        default:    k = kbit($urandom_range(0, 15)) | kbit($urandom_range(0, 15));
      endcase
      run_frame(k);
      prev = k;
    end
    run_n('0, 3);

    // Reset while a key is held: immediate return to reset values, no release strobe
    run_n(kbit(5), 4);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check_reset_vals("rst_mid");
    keys = '0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    run_n(kbit(5), 4);
    run_n('0, 3);

    @(posedge clk); #1;
    check("total_valid",   32'(seen_valid), 32'(tot_valid));
    check("total_release", 32'(seen_rel),   32'(tot_rel));
    check("valid_and_release", 32'(seen_both), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
